// File: rtl/sponge_msg_packer.sv
// sponge_msg_packer
// Packs a stream of IN_W-bit message words into RATE-bit blocks for a sponge
// hash core, strobes each block into the core, and requests the squeeze once
// the message is complete. The digest is latched when the core reports end.
//
// Optional feature macro: SPONGE_PACKER_PAD_EN
//   defined   -> append a single 1 bit after the last message bit, then zeros;
//                a message that ends exactly on a block boundary gets an extra
//                block of 1 followed by RATE-1 zeros.
//   undefined -> no padding; a partial final block is zero-filled.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_data/in_valid/in_last message word stream (first word -> block MSBs)
//   in_ready                 word accepted when in_valid && in_ready
//   blk_data/blk_valid       rate block and one-cycle absorb strobe to the core
//   start_hash               one-cycle squeeze request to the core
//   core_busy/core_end       core status flags
//   core_digest              core digest, latched into digest_o on core_end
//   digest_o/digest_valid    latched digest of the last completed message
//   busy                     message in progress
module sponge_msg_packer #(
  parameter int IN_W = 8,
  parameter int RATE = 8,
  parameter int N    = 88
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [RATE-1:0] blk_data,
  output logic            blk_valid,
  output logic            start_hash,
  input  logic            core_busy,
  input  logic            core_end,
  input  logic [N-1:0]    core_digest,
  output logic [N-1:0]    digest_o,
  output logic            digest_valid,
  output logic            busy
);

  localparam int WORDS = (IN_W > 0) ? (RATE / IN_W) : 1;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  generate
    if ((IN_W < 1) || (RATE < IN_W) || ((RATE % IN_W) != 0)) begin : g_bad_rate
      $error("sponge_msg_packer: RATE must be a non-zero multiple of IN_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_ISSUE    = 3'd2,
    S_SETTLE   = 3'd3,
    S_PAD      = 3'd4,
    S_FINAL    = 3'd5,
    S_WAIT_END = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RATE-1:0] block_q, block_d;
  logic            msg_open_q, msg_open_d;   // words still expected for this message
  logic            pad_pend_q, pad_pend_d;   // extra padding block still owed
  logic            blk_valid_q, blk_valid_d;
  logic            start_hash_q, start_hash_d;
  logic [N-1:0]    digest_q, digest_d;
  logic            digest_valid_q, digest_valid_d;
  logic            busy_q, busy_d;

  logic            accept_s;
  logic            full_s;
  logic [31:0]     shamt_s;
  logic [RATE-1:0] word_ext_s;
  logic [RATE-1:0] word_vec_s;
  logic [RATE-1:0] msb_one_s;
  logic [RATE-1:0] pad_vec_s;
  logic            pad_set_s;

  // Handshake: ready only in word-accepting states and never while in reset.
  assign in_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_FILL) | (state_q == S_DONE));
  assign accept_s = in_valid & in_ready;
  assign full_s   = (cnt_q == CNT_W'(WORDS - 1));

  // Slot placement and padding vectors for the word being accepted.
  always_comb begin
    shamt_s            = 32'(cnt_q) * 32'(IN_W);
    word_ext_s         = '0;
    word_ext_s[RATE-1 -: IN_W] = in_data;
    word_vec_s         = word_ext_s >> shamt_s;
    msb_one_s          = '0;
    msb_one_s[RATE-1]  = 1'b1;
`ifdef SPONGE_PACKER_PAD_EN
    // Shift past the word just placed; a full block shifts the bit out entirely
    // and the pad moves to a separate block instead.
    pad_vec_s = msb_one_s >> (shamt_s + 32'(IN_W));
    pad_set_s = full_s;
`else
    pad_vec_s = '0;
    pad_set_s = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FILL, S_DONE: begin
        if (accept_s) begin
          state_d = (in_last || full_s) ? S_ISSUE : S_FILL;
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        if (!core_busy) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_SETTLE: begin
        // The strobe cycle itself is skipped: the core has not raised busy yet.
        if (blk_valid_q || core_busy) begin
          state_d = S_SETTLE;
        end else if (msg_open_q) begin
          state_d = S_FILL;
        end else if (pad_pend_q) begin
          state_d = S_PAD;
        end else begin
          state_d = S_FINAL;
        end
      end
      S_PAD:      state_d = S_ISSUE;
      S_FINAL:    state_d = S_WAIT_END;
      S_WAIT_END: begin
        if (core_end) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_END;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d          = cnt_q;
    block_d        = block_q;
    msg_open_d     = msg_open_q;
    pad_pend_d     = pad_pend_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    blk_valid_d    = (state_q == S_ISSUE) && !core_busy;
    start_hash_d   = (state_q == S_FINAL);
    busy_d         = !((state_d == S_IDLE) || (state_d == S_DONE));

    if (accept_s) begin
      block_d        = block_q | word_vec_s | (in_last ? pad_vec_s : {RATE{1'b0}});
      cnt_d          = (in_last || full_s) ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
      msg_open_d     = !in_last;
      pad_pend_d     = in_last && pad_set_s;
      digest_valid_d = 1'b0;
    end else if (blk_valid_q) begin
      block_d = '0;
    end else if (state_q == S_PAD) begin
      block_d    = msb_one_s;
      pad_pend_d = 1'b0;
    end else begin
      block_d = block_q;
    end

    if ((state_q == S_WAIT_END) && core_end) begin
      digest_d       = core_digest;
      digest_valid_d = 1'b1;
    end else begin
      digest_d = digest_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      block_q        <= '0;
      msg_open_q     <= 1'b0;
      pad_pend_q     <= 1'b0;
      blk_valid_q    <= 1'b0;
      start_hash_q   <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      block_q        <= block_d;
      msg_open_q     <= msg_open_d;
      pad_pend_q     <= pad_pend_d;
      blk_valid_q    <= blk_valid_d;
      start_hash_q   <= start_hash_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign blk_data     = block_q;
  assign blk_valid    = blk_valid_q;
  assign start_hash   = start_hash_q;
  assign digest_o     = digest_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sponge_msg_packer.sv
// Testbench for sponge_msg_packer (IN_W=8, RATE=24, N=88).
// Expected blocks come from a bit-string model of the message: words are laid
// MSB-first into RATE-bit blocks, then the padding rule is applied.
module tb_sponge_msg_packer;

  localparam int IN_W  = 8;
  localparam int RATE  = 24;
  localparam int N     = 88;
  localparam int WORDS = RATE / IN_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [RATE-1:0] blk_data;
  logic            blk_valid;
  logic            start_hash;
  logic            core_busy;
  logic            core_end;
  logic [N-1:0]    core_digest;
  logic [N-1:0]    digest_o;
  logic            digest_valid;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0] msg_q[$];
  logic [RATE-1:0] exp_q[$];
  logic [RATE-1:0] got_q[$];
  int              start_cnt   = 0;
  int              overlap_cnt = 0;
  int              end_wait    = 0;
  bit              rand_busy   = 1'b0;
  bit              busy_force  = 1'b0;
  logic [N-1:0]    next_digest = '0;

  always #5 clk = ~clk;

  sponge_msg_packer #(.IN_W(IN_W), .RATE(RATE), .N(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .blk_data(blk_data), .blk_valid(blk_valid), .start_hash(start_hash),
    .core_busy(core_busy), .core_end(core_end), .core_digest(core_digest),
    .digest_o(digest_o), .digest_valid(digest_valid), .busy(busy)
  );

  // Core model and block monitor, acting just after each falling edge.
  initial begin
    core_busy = 1'b0; core_end = 1'b0; core_digest = '0;
    forever begin
      @(negedge clk);
      #1;
      if (blk_valid) got_q.push_back(blk_data);
      if (blk_valid && start_hash) overlap_cnt++;
      core_end  = 1'b0;
      core_busy = rand_busy ? ($urandom_range(0, 3) == 0) : busy_force;
      if (start_hash) begin
        start_cnt++;
        end_wait = $urandom_range(1, 4);
      end else if (end_wait > 0) begin
        end_wait--;
        if (end_wait == 0) begin
          core_digest = next_digest;
          core_end    = 1'b1;
        end
      end
    end
  end

  // Reference model: lay message bits into blocks and apply padding.
  function automatic void build_exp();
    logic [RATE-1:0] cur;
    int slot;
    exp_q.delete();
    cur  = '0;
    slot = 0;
    foreach (msg_q[i]) begin
      cur[RATE-1-slot*IN_W -: IN_W] = msg_q[i];
      slot++;
      if (slot == WORDS) begin
        exp_q.push_back(cur);
        cur  = '0;
        slot = 0;
      end
    end
`ifdef SPONGE_PACKER_PAD_EN
    cur[RATE-1-slot*IN_W] = 1'b1;
    exp_q.push_back(cur);
`else
    if (slot != 0) exp_q.push_back(cur);
`endif
  endfunction

  // Feed msg_q with random gaps, and garbage offered while not ready.
  task automatic send_msg();
    int idx   = 0;
    int guard = 0;
    while (idx < msg_q.size() && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (in_ready && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = msg_q[idx];
        in_last  = (idx == msg_q.size() - 1);
        idx++;
      end else if (in_ready) begin
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
        in_last  = 1'b0;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = IN_W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (idx != msg_q.size()) begin
      errors++;
      $display("FAIL send_timeout: sent %0d words, required %0d", idx, msg_q.size());
    end
  endtask

  // Wait (bounded) for the digest of the current message.
  task automatic wait_digest();
    int guard = 0;
    while (!digest_valid && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checks++;
    if (digest_valid !== 1'b1) begin
      errors++;
      $display("FAIL digest_timeout: digest_valid=%b, required 1", digest_valid);
    end
  endtask

  task automatic run_msg();
    got_q.delete();
    start_cnt = 0;
    build_exp();
    send_msg();
    wait_digest();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(negedge clk);
    checks++;
    if ({in_ready, blk_valid, start_hash, digest_valid, busy} !== 5'b0 || blk_data !== '0 || digest_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b bv=%b sh=%b dv=%b busy=%b blk=%h dig=%h, required all 0",
               in_ready, blk_valid, start_hash, digest_valid, busy, blk_data, digest_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [RATE-1:0] want[$];
    for (int k = 0; k < 3; k++) begin
      msg_q.delete();
      want.delete();
      next_digest = N'({$urandom, $urandom, $urandom});
      case (k)
        0: begin
          msg_q.push_back(8'h41);
`ifdef SPONGE_PACKER_PAD_EN
          want.push_back(24'h418000);
`else
          want.push_back(24'h410000);
`endif
        end
        1: begin
          msg_q.push_back(8'hAB); msg_q.push_back(8'hCD); msg_q.push_back(8'hEF);
          want.push_back(24'hABCDEF);
`ifdef SPONGE_PACKER_PAD_EN
          want.push_back(24'h800000);
`endif
        end
        default: begin
          msg_q.push_back(8'h11); msg_q.push_back(8'h22);
          msg_q.push_back(8'h33); msg_q.push_back(8'h44);
          want.push_back(24'h112233);
`ifdef SPONGE_PACKER_PAD_EN
          want.push_back(24'h448000);
`else
          want.push_back(24'h440000);
`endif
        end
      endcase
      run_msg();
      checks++;
      if (got_q.size() != want.size()) begin
        errors++;
        $display("FAIL directed_%0d_count: got %0d blocks, required %0d", k, got_q.size(), want.size());
      end else begin
        foreach (want[i]) begin
          checks++;
          if (got_q[i] !== want[i]) begin
            errors++;
            $display("FAIL directed_%0d_blk%0d: got %h, required %h", k, i, got_q[i], want[i]);
          end
        end
      end
      checks++;
      if (start_cnt != 1 || digest_o !== next_digest) begin
        errors++;
        $display("FAIL directed_%0d_final: start_hash strobes %0d digest %h, required 1 %h",
                 k, start_cnt, digest_o, next_digest);
      end
    end
  endtask

  task automatic test_busy_stall();
    int bad = 0;
    rand_busy  = 1'b0;
    busy_force = 1'b1;
    msg_q.delete();
    msg_q.push_back(8'h5A);
    build_exp();
    got_q.delete();
    start_cnt   = 0;
    next_digest = N'({$urandom, $urandom, $urandom});
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (blk_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    busy_force = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_quiet: %0d stalled cycles had blk_valid/in_ready high, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_strobe: blk_valid=%b after busy fell, required 1", blk_valid);
    end
    @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_strobe_width: blk_valid=%b second cycle, required 0", blk_valid);
    end
    wait_digest();
    checks++;
    if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL stall_blocks: got %0d blocks first %h, required %0d first %h",
               got_q.size(), got_q[0], exp_q.size(), exp_q[0]);
    end
    rand_busy = 1'b1;
  endtask

  task automatic test_random();
    for (int m = 0; m < 25; m++) begin
      int n;
      n = $urandom_range(1, 7);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(IN_W'($urandom));
      next_digest = N'({$urandom, $urandom, $urandom});
      run_msg();
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random_%0d_count: got %0d blocks, required %0d", m, got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random_%0d_blk%0d: got %h, required %h", m, i, got_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (start_cnt != 1 || digest_o !== next_digest || busy !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d_final: strobes %0d digest %h busy %b, required 1 %h 0",
                 m, start_cnt, digest_o, busy, next_digest);
      end
    end
    checks++;
    if (overlap_cnt != 0) begin
      errors++;
      $display("FAIL strobe_overlap: %0d cycles with blk_valid and start_hash, required 0", overlap_cnt);
    end
  endtask

  task automatic test_digest();
    msg_q.delete();
    msg_q.push_back(IN_W'($urandom));
    msg_q.push_back(IN_W'($urandom));
    next_digest = 88'h0123456789ABCDEF012345;
    run_msg();
    checks++;
    if (digest_o !== 88'h0123456789ABCDEF012345 || digest_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL digest_latch: digest %h dv %b busy %b, required 0123456789abcdef012345 1 0",
               digest_o, digest_valid, busy);
    end
    // One word that does not end the message: held in FILL for the reset test.
    in_valid = 1'b1; in_data = 8'hC3; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (digest_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL digest_clear: dv %b busy %b after accept, required 0 1", digest_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, blk_valid, start_hash, digest_valid, busy} !== 5'b0 || blk_data !== '0 || digest_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b bv=%b sh=%b dv=%b busy=%b blk=%h dig=%h, required all 0",
               in_ready, blk_valid, start_hash, digest_valid, busy, blk_data, digest_o);
    end
    @(negedge clk);
    rst = 1'b0;
    msg_q.delete();
    msg_q.push_back(8'h41);
    next_digest = N'({$urandom, $urandom, $urandom});
    run_msg();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() != 1) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d blocks, required %0d", got_q.size(), exp_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL reset_mid_blk: got %h, required %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    rand_busy = 1'b1;
    test_directed();
    test_busy_stall();
    test_random();
    test_digest();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sponge_msg_packer.md
SPONGE_MSG_PACKER -- requirements
Module: sponge_msg_packer

Interface
REQ-001 Parameter IN_W, default 8: input word width in bits.
REQ-002 Parameter RATE, default 8: sponge rate r in bits; SHALL be a multiple of IN_W, illegal values rejected at elaboration.
REQ-003 Parameter N, default 88: digest width in bits.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_data  in  IN_W  message word; first word of a block occupies the block MSBs.
REQ-008 in_valid  in  1  in_data valid; word accepted when in_valid and in_ready are both high on a clock edge.
REQ-009 in_last  in  1  qualifies the accepted word as the final message word.
REQ-010 in_ready  out  1  packer can accept a word this cycle.
REQ-011 blk_data  out  RATE  rate block to the sponge core data_input.
REQ-012 blk_valid  out  1  one-cycle absorb strobe to core data_ready.
REQ-013 start_hash  out  1  one-cycle strobe to core start_hash (squeeze request).
REQ-014 core_busy  in  1  core busy flag.
REQ-015 core_end  in  1  core end_hash flag.
REQ-016 core_digest  in  N  core digest.
REQ-017 digest_o  out  N  latched digest.
REQ-018 digest_valid  out  1  digest_o holds the digest of the last completed message.
REQ-019 busy  out  1  message in progress (any state except IDLE and DONE).

Function
REQ-020 FSM states SHALL be IDLE, FILL, ISSUE, SETTLE, PAD, FINAL, WAIT_END, DONE.
REQ-021 Word counter SHALL count 0..RATE/IN_W-1; accepted word placed at slot cnt counted from MSB.
REQ-022 in_ready SHALL be high only in IDLE, FILL and DONE.
REQ-023 IDLE/DONE: accepted word -> FILL (or ISSUE if block full); acceptance in DONE clears digest_valid on the same edge.
REQ-024 Block full (counter wraps) or in_last accepted -> ISSUE.
REQ-025 ISSUE: wait while core_busy high; when low, blk_valid high for exactly one cycle with blk_data stable, then SETTLE.
REQ-026 SETTLE: ignore core_busy for one cycle, then wait for core_busy low; next state FILL if message open, PAD if pad block pending, else FINAL.
REQ-027 FINAL: start_hash high for exactly one cycle, then WAIT_END.
REQ-028 WAIT_END: on core_end high, latch core_digest into digest_o, set digest_valid, go to DONE.
REQ-029 blk_valid and start_hash SHALL never be high in the same cycle.
REQ-030 Partial final block: unused LSB slots SHALL be zero apart from padding per REQ-034.
REQ-031 in_valid without in_ready SHALL be ignored; in_last is only sampled on an accepted word.
REQ-032 Block register cleared after each blk_valid strobe.

Reset
REQ-033 rst high SHALL at once force IDLE, counter 0, block register 0, in_ready 0 while asserted and 1 in IDLE after release, blk_valid 0, start_hash 0, digest_o 0, digest_valid 0, busy 0; a message interrupted mid-operation is discarded.

Configuration
REQ-034 Macro SPONGE_PACKER_PAD_EN defined: packer SHALL append a single 1 bit immediately after the last message bit, then zeros to the block end; if the last word exactly fills the block, that block is issued unmodified and PAD issues an extra block of value 1 followed by RATE-1 zeros.
REQ-035 SPONGE_PACKER_PAD_EN undefined: no padding, no PAD state reachable; final partial block zero-filled; caller supplies padding.

Verification
REQ-036 PAD_EN, IN_W=8, RATE=8: word 0x41 with in_last -> blk_valid strobes with blk_data 0x41 then 0x80, then one start_hash strobe.
REQ-037 PAD_EN, IN_W=8, RATE=16: words 0xAB, 0xCD, 0xEF (last) -> blocks 0xABCD, 0xEF80; without macro -> 0xABCD, 0xEF00.
REQ-038 core_busy held high 10 cycles during ISSUE -> blk_valid and in_ready stay low for those 10 cycles; single strobe in the cycle after core_busy falls.
REQ-039 core_end pulse with core_digest 0x0123456789ABCDEF012345 (N=88) -> digest_o equals it, digest_valid high, busy low; digest_valid drops when the next word is accepted.
REQ-040 rst asserted with one word held in FILL -> all outputs return to reset values within the same cycle; following message 0x41 (last) yields blocks 0x41, 0x80 only.
